// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, total-period helpers and the colour-bar lookup
// used by vga_timing_out and its delay line.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int calc_h_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int calc_v_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   // Returns {r, g, b}; bar order is black, red, green, yellow, blue, magenta, cyan, white.
   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register advancing on en, with synchronous reset to
// RESET_VAL; DEPTH=0 degenerates to a plain wire.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused_ctrl;
         assign w_unused_ctrl = ^{clk, rst, en};
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
            end else if (en) begin
               r_stage[0] <= d;
               for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
         end

         assign q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// Parametrised VGA timing generator and registered, blanked RGB output stage.
// Defining VGA_TEST_PATTERN_EN adds an internal colour-bar source selected by test_en.
module vga_timing_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 1,
   parameter int PIPE_LAT = 2,
   localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int XW      = $clog2(H_TOTAL),
   localparam int YW      = $clog2(V_TOTAL)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_en,
   input  logic               test_en,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [XW-1:0]      x,
   output logic [YW-1:0]      y,
   output logic               active,
   output logic               line_start,
   output logic               frame_start,
   output logic               vga_h_sync,
   output logic               vga_v_sync,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b
);

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
          (H_ACTIVE % 8) != 0 || PIPE_LAT < 0 || COLOR_W < 1) begin : g_bad_param
         $error("vga_timing_out: illegal timing parameters");
      end
   endgenerate

   logic [XW-1:0]      r_x;
   logic [YW-1:0]      r_y;
   logic               w_x_last, w_y_last;
   logic               w_active, w_hs_raw, w_vs_raw;
   logic [2:0]         w_ctrl_d;
   logic               w_hs_d, w_vs_d, w_active_d;
   logic [COLOR_W-1:0] w_src_r, w_src_g, w_src_b;
   logic               r_h_sync, r_v_sync;
   logic [COLOR_W-1:0] r_r, r_g, r_b;

   assign w_x_last = (r_x == XW'(H_TOTAL - 1));
   assign w_y_last = (r_y == YW'(V_TOTAL - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (pix_en) begin
         if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   assign w_active = (r_x < XW'(H_ACTIVE)) && (r_y < YW'(V_ACTIVE));
   assign w_hs_raw = (r_x >= XW'(H_ACTIVE + H_FP)) && (r_x < XW'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vs_raw = (r_y >= YW'(V_ACTIVE + V_FP)) && (r_y < YW'(V_ACTIVE + V_FP + V_SYNC));

   // Strobes are gated by rst so they stay quiet while reset is held.
   assign line_start  = pix_en && !rst && (r_x == '0);
   assign frame_start = line_start && (r_y == '0);

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_LAT),
      .RESET_VAL (3'b000)
   ) u_dl_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (pix_en),
      .d   ({w_hs_raw, w_vs_raw, w_active}),
      .q   (w_ctrl_d)
   );

   assign w_hs_d     = w_ctrl_d[2];
   assign w_vs_d     = w_ctrl_d[1];
   assign w_active_d = w_ctrl_d[0];

`ifdef VGA_TEST_PATTERN_EN
   logic [XW-1:0] w_x_d;
   logic [2:0]    w_bar_idx;
   logic [2:0]    w_bar_rgb;

   vga_delay_line #(
      .WIDTH     (XW),
      .DEPTH     (PIPE_LAT),
      .RESET_VAL ('0)
   ) u_dl_x (
      .clk (clk),
      .rst (rst),
      .en  (pix_en),
      .d   (r_x),
      .q   (w_x_d)
   );

   assign w_bar_idx = 3'(w_x_d / XW'(H_ACTIVE / 8));
   assign w_bar_rgb = bar_rgb(w_bar_idx);
   assign w_src_r   = test_en ? {COLOR_W{w_bar_rgb[2]}} : pix_r;
   assign w_src_g   = test_en ? {COLOR_W{w_bar_rgb[1]}} : pix_g;
   assign w_src_b   = test_en ? {COLOR_W{w_bar_rgb[0]}} : pix_b;
`else
   logic w_unused_test_en;
   assign w_unused_test_en = test_en;
   assign w_src_r = pix_r;
   assign w_src_g = pix_g;
   assign w_src_b = pix_b;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_sync <= ~HS_POL;
         r_v_sync <= ~VS_POL;
         r_r      <= '0;
         r_g      <= '0;
         r_b      <= '0;
      end else if (pix_en) begin
         r_h_sync <= w_hs_d ~^ HS_POL;
         r_v_sync <= w_vs_d ~^ VS_POL;
         r_r      <= w_active_d ? w_src_r : '0;
         r_g      <= w_active_d ? w_src_g : '0;
         r_b      <= w_active_d ? w_src_b : '0;
      end
   end

   assign x          = r_x;
   assign y          = r_y;
   assign active     = w_active;
   assign vga_h_sync = r_h_sync;
   assign vga_v_sync = r_v_sync;
   assign vga_r      = r_r;
   assign vga_g      = r_g;
   assign vga_b      = r_b;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: default 640x480 timing plus two reduced-timing
// instances, all checked against a position-count reference model.
module tb_vga_timing_out;

   logic clk, rst, pix_en, test_en;

   logic       d_pr, d_pg, d_pb, d_act, d_ls, d_fs, d_hs, d_vs, d_r, d_g, d_b;
   logic [9:0] d_x, d_y;
   logic       s_pr, s_pg, s_pb, s_act, s_ls, s_fs, s_hs, s_vs, s_r, s_g, s_b;
   logic [4:0] s_x;
   logic [3:0] s_y;
   logic [3:0] p_pr, p_pg, p_pb, p_r, p_g, p_b;
   logic       p_act, p_ls, p_fs, p_hs, p_vs;
   logic [4:0] p_x;
   logic [3:0] p_y;

   logic [39:0] obs_d, obs_s, obs_p;

   int n_checks = 0;
   int n_errors = 0;
   int n = 0;

   // Per-instance timing: 0 = defaults, 1 = reduced, 2 = reduced with inverted polarity and no latency
   int HA[3]  = '{640, 16, 16};
   int HF[3]  = '{16, 2, 2};
   int HSY[3] = '{96, 3, 3};
   int HB[3]  = '{48, 3, 3};
   int VA[3]  = '{480, 6, 6};
   int VF[3]  = '{10, 1, 1};
   int VSY[3] = '{2, 2, 2};
   int VB[3]  = '{33, 1, 1};
   int LAT[3] = '{2, 2, 0};
   bit HP[3]  = '{1'b0, 1'b0, 1'b1};
   bit VP[3]  = '{1'b0, 1'b0, 1'b1};

   logic [2:0]  tab_d [97];
   logic [2:0]  tab_s [97];
   logic [11:0] tab_p [97];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   vga_timing_out u_def (
      .clk (clk), .rst (rst), .pix_en (pix_en), .test_en (test_en),
      .pix_r (d_pr), .pix_g (d_pg), .pix_b (d_pb),
      .x (d_x), .y (d_y), .active (d_act), .line_start (d_ls), .frame_start (d_fs),
      .vga_h_sync (d_hs), .vga_v_sync (d_vs), .vga_r (d_r), .vga_g (d_g), .vga_b (d_b)
   );

   vga_timing_out #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL (1'b0), .VS_POL (1'b0), .COLOR_W (1), .PIPE_LAT (2)
   ) u_sml (
      .clk (clk), .rst (rst), .pix_en (pix_en), .test_en (test_en),
      .pix_r (s_pr), .pix_g (s_pg), .pix_b (s_pb),
      .x (s_x), .y (s_y), .active (s_act), .line_start (s_ls), .frame_start (s_fs),
      .vga_h_sync (s_hs), .vga_v_sync (s_vs), .vga_r (s_r), .vga_g (s_g), .vga_b (s_b)
   );

   vga_timing_out #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
      .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL (1'b1), .VS_POL (1'b1), .COLOR_W (4), .PIPE_LAT (0)
   ) u_pol (
      .clk (clk), .rst (rst), .pix_en (pix_en), .test_en (test_en),
      .pix_r (p_pr), .pix_g (p_pg), .pix_b (p_pb),
      .x (p_x), .y (p_y), .active (p_act), .line_start (p_ls), .frame_start (p_fs),
      .vga_h_sync (p_hs), .vga_v_sync (p_vs), .vga_r (p_r), .vga_g (p_g), .vga_b (p_b)
   );

   assign obs_d = {3'b0, d_x, d_y, d_act, d_ls, d_fs, d_hs, d_vs, 9'b0, d_r, d_g, d_b};
   assign obs_s = {3'b0, 5'b0, s_x, 6'b0, s_y, s_act, s_ls, s_fs, s_hs, s_vs, 9'b0, s_r, s_g, s_b};
   assign obs_p = {3'b0, 5'b0, p_x, 6'b0, p_y, p_act, p_ls, p_fs, p_hs, p_vs, p_r, p_g, p_b};

   function automatic logic [39:0] obs_of(input int k);
      case (k)
         0:       return obs_d;
         1:       return obs_s;
         default: return obs_p;
      endcase
   endfunction

   // Colour the source presents for frame position q (q counts enables since reset).
   function automatic logic [11:0] src_col(input int k, input int q);
      case (k)
         0:       return {9'b0, tab_d[q % 97]};
         1:       return {9'b0, tab_s[q % 97]};
         default: return tab_p[q % 97];
      endcase
   endfunction

   // Expected {x, y, active, line_start, frame_start, h_sync, v_sync, colour}
   // after p enables since reset; the output stage shows position p-1-latency.
   function automatic logic [39:0] exp_vec(input int k, input int p, input bit strobe_en, input bit te);
      int ht, vt, px, py, q, xq, yq;
      bit act, ls, fs, hs_lvl, vs_lvl;
      logic [2:0] bi;
      logic [11:0] col;
      ht = HA[k] + HF[k] + HSY[k] + HB[k];
      vt = VA[k] + VF[k] + VSY[k] + VB[k];
      px = p % ht;
      py = (p / ht) % vt;
      act = (px < HA[k]) && (py < VA[k]);
      ls = strobe_en && (px == 0);
      fs = ls && (py == 0);
      q = p - 1 - LAT[k];
      hs_lvl = !HP[k];
      vs_lvl = !VP[k];
      col = '0;
      if (q >= 0) begin
         xq = q % ht;
         yq = (q / ht) % vt;
         if (xq >= HA[k] + HF[k] && xq < HA[k] + HF[k] + HSY[k]) hs_lvl = HP[k];
         if (yq >= VA[k] + VF[k] && yq < VA[k] + VF[k] + VSY[k]) vs_lvl = VP[k];
         if (xq < HA[k] && yq < VA[k]) begin
            col = src_col(k, q);
`ifdef VGA_TEST_PATTERN_EN
            if (te) begin
               bi = 3'(xq / (HA[k] / 8));
               if (k == 2) col = {{4{bi[0]}}, {4{bi[1]}}, {4{bi[2]}}};
               else        col = {9'b0, bi[0], bi[1], bi[2]};
            end
`else
            bi = {2'b0, te};
`endif
         end
      end
      return {3'b0, 10'(px), 10'(py), act, ls, fs, hs_lvl, vs_lvl, col};
   endfunction

   // One clock: drive inputs at the falling edge, update the model at the rising edge.
   task automatic tick(input bit en, input bit r);
      logic [11:0] junk;
      rst = r;
      pix_en = en;
      junk = 12'($urandom);
      if (en) begin
         {d_pr, d_pg, d_pb} = (n >= 2) ? tab_d[(n - 2) % 97] : junk[2:0];
         {s_pr, s_pg, s_pb} = (n >= 2) ? tab_s[(n - 2) % 97] : junk[5:3];
         {p_pr, p_pg, p_pb} = tab_p[n % 97];
      end else begin
         {d_pr, d_pg, d_pb} = junk[2:0];
         {s_pr, s_pg, s_pb} = junk[5:3];
         {p_pr, p_pg, p_pb} = 12'($urandom);
      end
      @(posedge clk);
      if (r) n = 0;
      else if (en) n++;
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [39:0] e, o;
      for (int i = 0; i < 3; i++) begin
         tick(i != 1, 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, 0, 1'b0, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL reset dut%0d cyc=%0d got=%h exp=%h", k, i, o, e);
            end
         end
      end
   endtask

   task automatic test_default_hline;
      logic [39:0] e, o;
      int low_cnt, samples;
      low_cnt = 0;
      samples = 0;
      for (int i = 0; i < 4800; i++) begin
         tick((i % 2) == 0, 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, n, pix_en && !rst, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL hline dut%0d n=%0d got=%h exp=%h", k, n, o, e);
            end
         end
         if (pix_en && n > 100 && samples < 800) begin
            samples++;
            if (d_hs == 1'b0) low_cnt++;
         end
      end
      n_checks++;
      if (low_cnt != 96) begin
         n_errors++;
         $display("FAIL hsync_low_width got=%0d exp=96", low_cnt);
      end
   endtask

   task automatic test_frames;
      logic [39:0] e, o;
      for (int i = 0; i < 1200; i++) begin
         tick(1'($urandom_range(0, 1)), 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, n, pix_en && !rst, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL frames dut%0d n=%0d got=%h exp=%h", k, n, o, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [39:0] e, o;
      tick(1'b1, 1'b1);
      for (int i = 0; i < 6000 && n < 1100; i++) tick(1'($urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (n != 1100) begin
         n_errors++;
         $display("FAIL reach_mid_frame got=%0d exp=1100", n);
      end
      tick(1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         e = exp_vec(k, 0, 1'b0, test_en);
         o = obs_of(k);
         n_checks++;
         if (o !== e) begin
            n_errors++;
            $display("FAIL mid_reset dut%0d got=%h exp=%h", k, o, e);
         end
      end
      rst = 1'b0;
      pix_en = 1'b1;
      #1;
      n_checks++;
      if ({d_fs, s_fs, p_fs} !== 3'b111) begin
         n_errors++;
         $display("FAIL frame_start_after_reset got=%b exp=111", {d_fs, s_fs, p_fs});
      end
      for (int i = 0; i < 60; i++) begin
         tick(1'b1, 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, n, pix_en && !rst, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL post_reset dut%0d n=%0d got=%h exp=%h", k, n, o, e);
            end
         end
      end
   endtask

   task automatic test_freeze;
      logic [39:0] e, o;
      for (int i = 0; i < 40 && (n % 24) != 10; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, n, 1'b0, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL freeze dut%0d cyc=%0d got=%h exp=%h", k, i, o, e);
            end
         end
      end
   endtask

   task automatic test_pattern;
      logic [39:0] e, o;
      test_en = 1'b1;
      tick(1'b1, 1'b0);
      for (int i = 0; i < 900; i++) begin
         tick(1'b1, 1'b0);
         for (int k = 0; k < 3; k++) begin
            e = exp_vec(k, n, pix_en && !rst, test_en);
            o = obs_of(k);
            n_checks++;
            if (o !== e) begin
               n_errors++;
               $display("FAIL pattern dut%0d n=%0d got=%h exp=%h", k, n, o, e);
            end
         end
      end
      test_en = 1'b0;
      tick(1'b1, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 97; i++) begin
         tab_d[i] = 3'($urandom);
         tab_s[i] = 3'($urandom);
         tab_p[i] = 12'($urandom);
      end
      rst = 1'b1;
      pix_en = 1'b0;
      test_en = 1'b0;
      {d_pr, d_pg, d_pb} = '0;
      {s_pr, s_pg, s_pb} = '0;
      {p_pr, p_pg, p_pb} = '0;
      @(negedge clk);
      test_reset();
      test_default_hline();
      test_frames();
      test_reset_mid();
      test_freeze();
      test_pattern();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
